iter_add_sub: RTL and testbench

ITER_ADD_SUB -- requirements
Module: iter_add_sub

---
 rtl/add_sub_pkg.sv | 11 +
 rtl/chunk_adder.sv | 31 +++
 rtl/full_adder.sv | 13 +
 rtl/iter_add_sub.sv | 114 +++++++++++
 tb/tb_iter_add_sub.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/add_sub_pkg.sv
// Shared definitions for the iterative adder/subtractor.
// The state encoding is kept as plain localparams so legacy blocks can reuse it.
package add_sub_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'b00;
  localparam state_t RUN  = 2'b01;
  localparam state_t DONE = 2'b10;

endpackage

// File: rtl/chunk_adder.sv
// CHUNK-bit ripple adder built from full_adder cells.
// Also exposes the carry into the MSB so the caller can derive signed overflow.
module chunk_adder #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             carryout,
  output logic             carry_msb
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .s   (sum[i]),
      .cout(c[i+1])
    );
  end

  assign carryout  = c[CHUNK];
  assign carry_msb = c[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// 1-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/iter_add_sub.sv
// Iterative adder/subtractor: one CHUNK-bit slice per cycle, NCHUNK cycles per operation,
// valid/ready handshake on both sides.
module iter_add_sub
  import add_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             subtract,
  input  logic             carryin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("iter_add_sub: WIDTH must be a multiple of CHUNK");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, sum_q, sum_d;
  logic             carry_q;
  logic [IW-1:0]    idx_q;
  logic             carryout_q, overflow_q, zero_q;

  logic             last;
  int unsigned      base;
  logic [CHUNK-1:0] chunk_sum;
  logic             chunk_co, chunk_cmsb;

  assign last = (idx_q == IW'(NCHUNK - 1));
  assign base = 32'(idx_q) * CHUNK;

  chunk_adder #(
    .CHUNK(CHUNK)
  ) u_chunk_adder (
    .a        (a_q[base +: CHUNK]),
    .b        (b_q[base +: CHUNK]),
    .cin      (carry_q),
    .sum      (chunk_sum),
    .carryout (chunk_co),
    .carry_msb(chunk_cmsb)
  );

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    sum_d[base +: CHUNK] = chunk_sum;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      carry_q    <= 1'b0;
      idx_q      <= '0;
      sum_q      <= '0;
      carryout_q <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is A + ~B + 1; carryin is ignored in that mode.
            a_q     <= a;
            b_q     <= b ^ {WIDTH{subtract}};
            carry_q <= subtract | carryin;
            idx_q   <= '0;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= chunk_co;
          idx_q   <= idx_q + IW'(1);
          if (last) begin
            carryout_q <= chunk_co;
            overflow_q <= chunk_cmsb ^ chunk_co;
            zero_q     <= (sum_d == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign carryout  = carryout_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_iter_add_sub.sv
// Bench for iter_add_sub: a CHUNK=8 instance and a CHUNK=WIDTH instance, checked against
// a plain-arithmetic reference model.
module tb_iter_add_sub;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a, b;
  logic        subtract, carryin;
  logic        in_valid  [2];
  logic        out_ready [2];
  logic        in_ready  [2];
  logic        out_valid [2];
  logic [31:0] sum       [2];
  logic        carryout  [2];
  logic        overflow  [2];
  logic        zero      [2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  iter_add_sub #(
    .WIDTH(32),
    .CHUNK(8)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid[0]),
    .in_ready (in_ready[0]),
    .a        (a),
    .b        (b),
    .subtract (subtract),
    .carryin  (carryin),
    .out_valid(out_valid[0]),
    .out_ready(out_ready[0]),
    .sum      (sum[0]),
    .carryout (carryout[0]),
    .overflow (overflow[0]),
    .zero     (zero[0])
  );

  iter_add_sub #(
    .WIDTH(32),
    .CHUNK(32)
  ) u_dut_wide (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid[1]),
    .in_ready (in_ready[1]),
    .a        (a),
    .b        (b),
    .subtract (subtract),
    .carryin  (carryin),
    .out_valid(out_valid[1]),
    .out_ready(out_ready[1]),
    .sum      (sum[1]),
    .carryout (carryout[1]),
    .overflow (overflow[1]),
    .zero     (zero[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain 33-bit arithmetic on the effective operands.
  task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic ms,
                       input logic mc, output logic [31:0] s, output logic co,
                       output logic ov, output logic z);
    logic [31:0] bb;
    logic [32:0] full;
    bb   = ms ? ~mb : mb;
    full = {1'b0, ma} + {1'b0, bb} + 33'(ms ? 1'b1 : mc);
    s    = full[31:0];
    co   = full[32];
    ov   = (ma[31] == bb[31]) && (s[31] != ma[31]);
    z    = (s == 32'd0);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_op(input int d, input logic [31:0] ta, input logic [31:0] tb,
                        input logic ts, input logic tc, input int hold, input string tag);
    logic [31:0] es;
    logic        eco, eov, ez;
    int          cnt;
    int          nch;
    nch = (d == 0) ? 4 : 1;
    model(ta, tb, ts, tc, es, eco, eov, ez);
    chk({tag, " in_ready"}, 32'(in_ready[d]), 32'd1);
    a = ta; b = tb; subtract = ts; carryin = tc;
    in_valid[d]  = 1'b1;
    out_ready[d] = (hold == 0);
    @(negedge clk);
    in_valid[d] = 1'b0;
    a = $urandom; b = $urandom; subtract = 1'($urandom); carryin = 1'($urandom);
    cnt = 0;
    while (!out_valid[d] && cnt < 40) begin
      @(negedge clk);
      cnt++;
      a = $urandom; b = $urandom;
    end
    chk({tag, " latency"}, 32'(cnt), 32'(nch));
    chk({tag, " sum"}, sum[d], es);
    chk({tag, " carryout"}, 32'(carryout[d]), 32'(eco));
    chk({tag, " overflow"}, 32'(overflow[d]), 32'(eov));
    chk({tag, " zero"}, 32'(zero[d]), 32'(ez));
    for (int i = 0; i < hold; i++) begin
      in_valid[d] = 1'b1;
      a = $urandom; b = $urandom; subtract = 1'($urandom);
      @(negedge clk);
      chk({tag, " hold out_valid"}, 32'(out_valid[d]), 32'd1);
      chk({tag, " hold in_ready"}, 32'(in_ready[d]), 32'd0);
      chk({tag, " hold sum"}, sum[d], es);
      chk({tag, " hold flags"}, {29'd0, carryout[d], overflow[d], zero[d]},
          {29'd0, eco, eov, ez});
    end
    in_valid[d]  = 1'b0;
    out_ready[d] = 1'b1;
    @(negedge clk);
    chk({tag, " released"}, {30'd0, out_valid[d], in_ready[d]}, 32'b01);
  endtask

  initial begin
    reset = 1'b1;
    a = '0; b = '0; subtract = 1'b0; carryin = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b1;
    end
    #1;
    chk("reset sum", sum[0], 32'd0);
    chk("reset flags", {28'd0, out_valid[0], carryout[0], overflow[0], zero[0]}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post-reset in_ready", {30'd0, in_ready[1], in_ready[0]}, 32'b11);

    @(negedge clk);
    run_op(0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0, "add_ff_1");
    run_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, "add_ovf");
    run_op(0, 32'h0000_0005, 32'h0000_0005, 1'b1, 1'b0, 0, "sub_zero");
    run_op(0, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 0, "sub_ovf");
    run_op(0, 32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b1, 3, "hold");

    // Reset while RUN is at index 2 must abandon the operation.
    a = 32'h0101_0101; b = 32'h0202_0202; subtract = 1'b0; carryin = 1'b0;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid-run reset out_valid", 32'(out_valid[0]), 32'd0);
    chk("mid-run reset sum", sum[0], 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("after reset in_ready", {30'd0, in_ready[0], out_valid[0]}, 32'b10);
    repeat (6) @(negedge clk);
    chk("no abandoned result", 32'(out_valid[0]), 32'd0);
    run_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, "wrap");

    // Back-to-back random traffic on both builds.
    for (int i = 0; i < 24; i++)
      run_op(0, $urandom, $urandom, 1'($urandom), 1'($urandom), 0, "rand8");
    run_op(1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, "wide_ovf");
    run_op(1, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 2, "wide_sub_hold");
    for (int i = 0; i < 12; i++)
      run_op(1, $urandom, $urandom, 1'($urandom), 1'($urandom), 0, "rand32");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
